regfile_rename_ckpt: RTL

- Parametrised successor to the single-snapshot architectural register file with rename tags.
- Holds committed register values plus a per-register dirty bit and ROB tag, with NRD combinational read ports and commit forwarding.
- Adds CK_DEPTH branch checkpoints of the dirty/tag table, so a mispredict restores the rename state instead of clearing it.
- Sits between decoder (read/rename), ROB (commit, flush) and branch unit (resolve).

---
 rtl/regfile_rename_ckpt.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/regfile_rename_ckpt.sv
// rtl/regfile_rename_ckpt.sv - architectural register file with rename tags and branch checkpoints
module regfile_rename_ckpt #(
    parameter int XLEN     = 32,
    parameter int NREG     = 32,
    parameter int ROB_W    = 4,
    parameter int NRD      = 2,
    parameter int CK_DEPTH = 4,
    localparam int IDX_W   = $clog2(NREG),
    localparam int CK_W    = $clog2(CK_DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rdy,
    input  logic                   flush,
    input  logic [NRD*IDX_W-1:0]   rd_idx,
    output logic [NRD-1:0]         rd_dirty,
    output logic [NRD*ROB_W-1:0]   rd_tag,
    output logic [NRD*XLEN-1:0]    rd_val,
    input  logic                   cm_valid,
    input  logic [IDX_W-1:0]       cm_idx,
    input  logic [XLEN-1:0]        cm_val,
    input  logic [ROB_W-1:0]       cm_tag,
    input  logic                   dec_valid,
    input  logic [IDX_W-1:0]       dec_rd,
    input  logic [ROB_W-1:0]       dec_tag,
    input  logic                   ck_alloc,
    output logic [CK_W-1:0]        ck_id,
    output logic                   ck_full,
    input  logic                   rs_valid,
    input  logic [CK_W-1:0]        rs_id,
    input  logic                   rs_mispred
);

    logic [NREG-1:0][XLEN-1:0]                  val_q, val_d;
    logic [NREG-1:0]                            dirty_q, dirty_d;
    logic [NREG-1:0][ROB_W-1:0]                 tag_q, tag_d;
    logic [CK_DEPTH-1:0][NREG-1:0]              ckd_q, ckd_d;
    logic [CK_DEPTH-1:0][NREG-1:0][ROB_W-1:0]   ckt_q, ckt_d;
    logic [CK_DEPTH-1:0]                        ckv_q, ckv_d;
    logic [CK_W-1:0]                            head_q, head_d;
    logic [CK_W-1:0]                            tail_q, tail_d;

    logic            cmw;
    logic            cm_clr;
    logic            mispred;
    logic            alloc;
    logic [CK_W-1:0] span;
    logic [CK_W-1:0] off;

    // Commit qualifiers; x0 is never written and rdy=0 suppresses forwarding too
    assign cmw     = cm_valid && (cm_idx != '0) && rdy;
    assign cm_clr  = cmw && dirty_q[cm_idx] && (tag_q[cm_idx] == cm_tag);
    assign mispred = rs_valid && rs_mispred && ckv_q[rs_id];
    assign alloc   = ck_alloc && !ckv_q[tail_q];
    // Slots rs_id..tail-1 are younger than the mispredicted branch; span 0 means the ring is full
    assign span    = tail_q - rs_id;
    assign ck_full = ckv_q[tail_q];
    assign ck_id   = tail_q;

    // Combinational read ports with commit forwarding
    always_comb begin
        rd_dirty = '0;
        rd_tag   = '0;
        rd_val   = '0;
        for (int p = 0; p < NRD; p++) begin
            if (rd_idx[p*IDX_W +: IDX_W] != '0) begin
                rd_dirty[p]              = dirty_q[rd_idx[p*IDX_W +: IDX_W]];
                rd_tag[p*ROB_W +: ROB_W] = tag_q[rd_idx[p*IDX_W +: IDX_W]];
                rd_val[p*XLEN +: XLEN]   = val_q[rd_idx[p*IDX_W +: IDX_W]];
                if (cmw && (rd_idx[p*IDX_W +: IDX_W] == cm_idx)) begin
                    rd_val[p*XLEN +: XLEN] = cm_val;
                    if (cm_clr) begin
                        rd_dirty[p]              = 1'b0;
                        rd_tag[p*ROB_W +: ROB_W] = '0;
                    end
                end
            end
        end
    end

    // Next-state for table, checkpoint ring and pointers
    always_comb begin
        val_d   = val_q;
        dirty_d = dirty_q;
        tag_d   = tag_q;
        ckd_d   = ckd_q;
        ckt_d   = ckt_q;
        ckv_d   = ckv_q;
        head_d  = head_q;
        tail_d  = tail_q;
        off     = '0;

        if (cmw) begin
            val_d[cm_idx] = cm_val;
        end
        // Each live snapshot retires the committing producer on its own tag match
        for (int c = 0; c < CK_DEPTH; c++) begin
            if (ckv_q[c] && cmw && ckd_q[c][cm_idx] && (ckt_q[c][cm_idx] == cm_tag)) begin
                ckd_d[c][cm_idx] = 1'b0;
                ckt_d[c][cm_idx] = '0;
            end
        end

        if (flush) begin
            dirty_d = '0;
            tag_d   = '0;
            ckv_d   = '0;
            head_d  = '0;
            tail_d  = '0;
        end else begin
            if (mispred) begin
                dirty_d = ckd_d[rs_id];
                tag_d   = ckt_d[rs_id];
                for (int c = 0; c < CK_DEPTH; c++) begin
                    off = CK_W'(c) - rs_id;
                    if ((span == '0) || (off < span)) begin
                        ckv_d[c] = 1'b0;
                    end
                end
                tail_d = rs_id;
            end else begin
                if (cm_clr) begin
                    dirty_d[cm_idx] = 1'b0;
                    tag_d[cm_idx]   = '0;
                end
                if (dec_valid && (dec_rd != '0)) begin
                    dirty_d[dec_rd] = 1'b1;
                    tag_d[dec_rd]   = dec_tag;
                end
                if (alloc) begin
                    ckd_d[tail_q] = dirty_d;
                    ckt_d[tail_q] = tag_d;
                    ckv_d[tail_q] = 1'b1;
                    tail_d        = tail_q + 1'b1;
                end
                if (rs_valid && !rs_mispred && ckv_q[rs_id]) begin
                    ckv_d[rs_id] = 1'b0;
                end
            end
            // Head steps past one resolved slot per cycle while the ring is non-empty
            if (!ckv_d[head_q] && ((head_q != tail_d) || (|ckv_d))) begin
                head_d = head_q + 1'b1;
            end
        end
    end

    // State registers, frozen while rdy is low
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            val_q   <= '0;
            dirty_q <= '0;
            tag_q   <= '0;
            ckd_q   <= '0;
            ckt_q   <= '0;
            ckv_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
        end else if (rdy) begin
            val_q   <= val_d;
            dirty_q <= dirty_d;
            tag_q   <= tag_d;
            ckd_q   <= ckd_d;
            ckt_q   <= ckt_d;
            ckv_q   <= ckv_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

endmodule
